sprite_anim_mapper: RTL and testbench

Parametrised character-sprite colour mapper with a built-in walk-animation state machine. It sits between the VGA controller (DrawX/DrawY) and the DAC outputs. Each pixel, it fetches a palette index from a synchronous sprite-sheet ROM and maps it through the shared palette. Transparent or out-of-window pixels fall back to the background gradient. The animation frame and sprite position update only on the vertical-sync frame tick, so no frame is drawn with mixed state (no tearing).

---
 rtl/sprite_anim_mapper_pkg.sv | 40 ++++
 rtl/sprite_anim_mapper_rom.sv | 28 ++
 rtl/sprite_anim_mapper.sv | 155 +++++++++++++++
 tb/tb_sprite_anim_mapper.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_anim_mapper_pkg.sv
// Shared types and constants for the sprite mapper: animation phase and facing enums,
// the global colour palette and a bounded palette lookup.
package sprite_pkg;

    typedef enum logic [1:0] {
        REST1 = 2'd0,
        M1    = 2'd1,
        REST2 = 2'd2,
        M2    = 2'd3
    } anim_phase_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    localparam int NUM_FRAMES = 16;
    localparam int PAL_SIZE   = 23;
    localparam int PAL_IDX_W  = $clog2(PAL_SIZE);

    localparam logic [23:0] PALETTE [PAL_SIZE] = '{
        24'h800080, 24'h101010, 24'h202020, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'hFCFCFC, 24'h00FFFF, 24'hFF00FF, 24'h804000, 24'hC08040,
        24'hF0C090, 24'h406080, 24'h2040A0, 24'hA02020, 24'h20A020, 24'hE0E0E0,
        24'h606060, 24'hFF8000, 24'h8000FF, 24'h00C0C0, 24'hC0C000
    };

    // Indices past the end of the palette render as black.
    function automatic logic [23:0] palette_lookup(input logic [7:0] idx);
        logic [23:0] colour;
        colour = 24'h000000;
        if (idx < 8'(PAL_SIZE)) begin
            colour = PALETTE[idx[PAL_IDX_W-1:0]];
        end
        return colour;
    endfunction

endpackage

// File: rtl/sprite_anim_mapper_rom.sv
// Synchronous single-port sprite-sheet ROM with one cycle of read latency.
// Contents are a fixed generated pattern so the sheet needs no external image file.
module sprite_rom #(
    parameter int DEPTH    = 6144,
    parameter int PAL_BITS = 5,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [PAL_BITS-1:0] data_o
);

    logic [PAL_BITS-1:0] word_d;
    logic [PAL_BITS-1:0] data_q;

    // Pattern word = (addr + addr/16 + addr/512 + 1) mod 2^PAL_BITS.
    always_comb begin
        word_d = PAL_BITS'(addr_i) + PAL_BITS'(addr_i >> 4)
               + PAL_BITS'(addr_i >> 9) + PAL_BITS'(1);
    end

    always_ff @(posedge clk) begin
        data_q <= word_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/sprite_anim_mapper.sv
// Walk-animated sprite colour mapper: frame-tick driven animation state plus a
// two-stage render pipeline from DrawX/DrawY to the DAC colour outputs.
module sprite_anim_mapper
    import sprite_pkg::*;
#(
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 24,
    parameter int FRAME_DIV  = 8,
    parameter int PAL_BITS   = 5,
    parameter int TRANSP_IDX = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       Character_Moving,
    input  logic [1:0] Direction,
    input  logic [9:0] SpriteX,
    input  logic [9:0] SpriteY,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       sprite_hit,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue
);

    localparam int FRAME_SIZE = SPRITE_W * SPRITE_H;
    localparam int DEPTH      = NUM_FRAMES * FRAME_SIZE;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(FRAME_DIV) + 1;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [PAL_BITS-1:0] TRANSP   = PAL_BITS'(TRANSP_IDX);

    dir_t             dir_q;
    anim_phase_t      phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       pos_x_q;
    logic [9:0]       pos_y_q;

    // Everything here moves only on the frame tick so a frame never mixes states.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dir_q   <= DOWN;
            phase_q <= REST1;
            cnt_q   <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else if (frame_tick) begin
            pos_x_q <= SpriteX;
            pos_y_q <= SpriteY;
            if (!Character_Moving) begin
                phase_q <= REST1;
                cnt_q   <= '0;
            end else if (Direction != dir_q) begin
                dir_q   <= dir_t'(Direction);
                phase_q <= REST1;
                cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                phase_q <= anim_phase_t'(phase_q + 2'd1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    logic [10:0]       win_x_end;
    logic [10:0]       win_y_end;
    logic              in_win;
    logic [9:0]        rel_x;
    logic [9:0]        rel_y;
    logic [3:0]        frame;
    logic [ADDR_W-1:0] addr_d;

    // Window ends are 11 bits wide so a sprite at the right/bottom edge cannot wrap.
    assign win_x_end = {1'b0, pos_x_q} + 11'(SPRITE_W);
    assign win_y_end = {1'b0, pos_y_q} + 11'(SPRITE_H);
    assign in_win    = (DrawX >= pos_x_q) && ({1'b0, DrawX} < win_x_end)
                    && (DrawY >= pos_y_q) && ({1'b0, DrawY} < win_y_end);

    assign rel_x  = DrawX - pos_x_q;
    assign rel_y  = DrawY - pos_y_q;
    assign frame  = {dir_q, phase_q};
    assign addr_d = ADDR_W'(32'(frame) * 32'(FRAME_SIZE)
                          + 32'(rel_y) * 32'(SPRITE_W) + 32'(rel_x));

    logic              s1_valid_q;
    logic              s1_in_win_q;
    logic [6:0]        s1_grad_x_q;
    logic [ADDR_W-1:0] addr_q;
    logic              s2_valid_q;
    logic              s2_in_win_q;
    logic [6:0]        s2_grad_x_q;
    logic [PAL_BITS-1:0] rom_idx;

    sprite_rom #(
        .DEPTH   (DEPTH),
        .PAL_BITS(PAL_BITS),
        .ADDR_W  (ADDR_W)
    ) u_rom (
        .clk   (Clk),
        .addr_i(addr_q),
        .data_o(rom_idx)
    );

    logic        hit_d;
    logic [23:0] rgb_d;
    logic        hit_q;
    logic [23:0] rgb_q;

    always_comb begin
        hit_d = 1'b0;
        rgb_d = 24'h000000;
        if (s2_valid_q) begin
            if (s2_in_win_q && (rom_idx != TRANSP)) begin
                hit_d = 1'b1;
                rgb_d = palette_lookup(8'(rom_idx));
            end else begin
                rgb_d = {16'h0000, 8'h7F - {1'b0, s2_grad_x_q}};
            end
        end
    end

    // Stage 1 samples the pixel, the ROM adds a cycle, stage 2 registers the colour.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_in_win_q <= 1'b0;
            s1_grad_x_q <= '0;
            addr_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_in_win_q <= 1'b0;
            s2_grad_x_q <= '0;
            hit_q       <= 1'b0;
            rgb_q       <= 24'h000000;
        end else begin
            s1_valid_q  <= 1'b1;
            s1_in_win_q <= in_win;
            s1_grad_x_q <= DrawX[9:3];
            addr_q      <= addr_d;
            s2_valid_q  <= s1_valid_q;
            s2_in_win_q <= s1_in_win_q;
            s2_grad_x_q <= s1_grad_x_q;
            hit_q       <= hit_d;
            rgb_q       <= rgb_d;
        end
    end

    assign sprite_hit = hit_q;
    assign Red        = rgb_q[23:16];
    assign Green      = rgb_q[15:8];
    assign Blue       = rgb_q[7:0];

endmodule

// File: tb/tb_sprite_anim_mapper.sv
// Self-checking bench for sprite_anim_mapper: directed scenarios plus a randomized
// pixel stream scored against a step-count based model of the animation and renderer.
module tb_sprite_anim_mapper;

    localparam int SW     = 16;
    localparam int SH     = 24;
    localparam int FDIV   = 8;
    localparam int TRANSP = 0;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       Character_Moving;
    logic [1:0] Direction;
    logic [9:0] SpriteX, SpriteY, DrawX, DrawY;
    logic       sprite_hit;
    logic [7:0] Red, Green, Blue;

    int checks = 0;
    int errors = 0;

    // Model: animation kept as a count of consecutive same-direction moving ticks.
    int m_dir, m_steps, m_px, m_py;

    logic [23:0] pal [23] = '{
        24'h800080, 24'h101010, 24'h202020, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'hFCFCFC, 24'h00FFFF, 24'hFF00FF, 24'h804000, 24'hC08040,
        24'hF0C090, 24'h406080, 24'h2040A0, 24'hA02020, 24'h20A020, 24'hE0E0E0,
        24'h606060, 24'hFF8000, 24'h8000FF, 24'h00C0C0, 24'hC0C000
    };

    logic [24:0] obs_pix;
    logic [3:0]  obs_frame;
    logic [3:0]  obs_cnt;
    logic [9:0]  obs_px, obs_py;
    assign obs_pix   = {sprite_hit, Red, Green, Blue};
    assign obs_frame = {dut.dir_q, dut.phase_q};
    assign obs_cnt   = dut.cnt_q;
    assign obs_px    = dut.pos_x_q;
    assign obs_py    = dut.pos_y_q;

    sprite_anim_mapper #(
        .SPRITE_W(SW), .SPRITE_H(SH), .FRAME_DIV(FDIV), .PAL_BITS(5), .TRANSP_IDX(TRANSP)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .Character_Moving(Character_Moving), .Direction(Direction),
        .SpriteX(SpriteX), .SpriteY(SpriteY), .DrawX(DrawX), .DrawY(DrawY),
        .sprite_hit(sprite_hit), .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #5 Clk = ~Clk;

    function automatic int m_frame();
        return m_dir * 4 + (m_steps / FDIV) % 4;
    endfunction

    function automatic int m_cnt();
        return m_steps % FDIV;
    endfunction

    function automatic int rom_model(input int a);
        return (a + a / 16 + a / 512 + 1) % 32;
    endfunction

    function automatic logic [24:0] exp_pixel(input int dx, input int dy);
        int a, idx;
        if (dx >= m_px && dx < m_px + SW && dy >= m_py && dy < m_py + SH) begin
            a   = m_frame() * SW * SH + (dy - m_py) * SW + (dx - m_px);
            idx = rom_model(a);
            if (idx != TRANSP) return {1'b1, (idx < 23) ? pal[idx] : 24'h000000};
        end
        return {1'b0, 16'h0000, 8'(127 - dx / 8)};
    endfunction

    task automatic model_reset();
        m_dir = 2; m_steps = 0; m_px = 0; m_py = 0;
    endtask

    task automatic model_tick(input bit mv, input int d, input int sx, input int sy);
        m_px = sx;
        m_py = sy;
        if (!mv) m_steps = 0;
        else if (d != m_dir) begin m_dir = d; m_steps = 0; end
        else m_steps++;
    endtask

    // Called just after a rising edge; returns just after the edge that took the tick.
    task automatic do_tick(input bit mv, input int d, input int sx, input int sy);
        Character_Moving = mv;
        Direction = 2'(d);
        SpriteX = 10'(sx);
        SpriteY = 10'(sy);
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        model_tick(mv, d, sx, sy);
    endtask

    task automatic test_reset();
        Reset = 1'b1; frame_tick = 1'b0; Character_Moving = 1'b0; Direction = 2'd0;
        SpriteX = '0; SpriteY = '0; DrawX = 10'd40; DrawY = 10'd5;
        repeat (3) @(posedge Clk); #1;
        checks++;
        if (obs_pix !== 25'h0) begin
            errors++; $display("FAIL reset_pix: got %h want %h", obs_pix, 25'h0);
        end
        checks++;
        if (obs_frame !== 4'd8 || obs_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_state: got frame %0d cnt %0d want frame 8 cnt 0", obs_frame, obs_cnt);
        end
        frame_tick = 1'b1; Character_Moving = 1'b1; SpriteX = 10'd55;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        checks++;
        if (obs_px !== 10'd0 || obs_frame !== 4'd8) begin
            errors++; $display("FAIL reset_tick_ignored: got posX %0d frame %0d want 0 8", obs_px, obs_frame);
        end
        Reset = 1'b0; Character_Moving = 1'b0; SpriteX = '0;
        model_reset();
        repeat (3) @(posedge Clk); #1;
        checks++;
        if (obs_pix !== {1'b0, 24'h00007A}) begin
            errors++; $display("FAIL reset_gradient: got %h want %h", obs_pix, {1'b0, 24'h00007A});
        end
        $display("test_reset done");
    endtask

    task automatic test_walk();
        for (int t = 1; t <= 32; t++) begin
            do_tick(1'b1, 2, 0, 0);
            checks++;
            if (obs_frame !== 4'(m_frame()) || obs_cnt !== 4'(m_cnt())) begin
                errors++;
                $display("FAIL walk_tick%0d: got frame %0d cnt %0d want frame %0d cnt %0d",
                         t, obs_frame, obs_cnt, m_frame(), m_cnt());
            end
            if (t == 8 || t == 16 || t == 24 || t == 32) begin
                checks++;
                if (obs_frame !== 4'(8 + (t / 8) % 4)) begin
                    errors++; $display("FAIL walk_phase_t%0d: got frame %0d want %0d", t, obs_frame, 8 + (t / 8) % 4);
                end
            end
        end
        $display("test_walk done");
    endtask

    task automatic test_turn_stop();
        for (int t = 0; t < 8; t++) do_tick(1'b1, 2, 0, 0);
        checks++;
        if (obs_frame !== 4'd9) begin
            errors++; $display("FAIL turn_pre_m1: got frame %0d want 9", obs_frame);
        end
        do_tick(1'b1, 1, 0, 0);
        checks++;
        if (obs_frame !== 4'd4 || obs_cnt !== 4'd0 || obs_frame !== 4'(m_frame())) begin
            errors++; $display("FAIL turn_right: got frame %0d cnt %0d want frame 4 cnt 0", obs_frame, obs_cnt);
        end
        do_tick(1'b0, 3, 0, 0);
        checks++;
        if (obs_frame !== 4'd4 || obs_cnt !== 4'd0 || obs_frame !== 4'(m_frame())) begin
            errors++; $display("FAIL stop_holds_dir: got frame %0d cnt %0d want frame 4 cnt 0", obs_frame, obs_cnt);
        end
        $display("test_turn_stop done");
    endtask

    task automatic test_window();
        int xs[$], ys[$];
        logic [24:0] expq[$];
        logic [24:0] e;
        int n;
        do_tick(1'b1, 2, 100, 200);
        checks++;
        if (obs_px !== 10'd100 || obs_py !== 10'd200 || obs_frame !== 4'd8) begin
            errors++; $display("FAIL window_latch: got pos %0d,%0d frame %0d want 100,200 8", obs_px, obs_py, obs_frame);
        end
        xs = '{100, 99, 115, 116, 115, 100, 107};
        ys = '{200, 200, 223, 223, 224, 199, 211};
        for (int o = 0; o < SW * SH; o++) begin
            if (rom_model(8 * SW * SH + o) == TRANSP) begin
                xs.push_back(100 + o % SW); ys.push_back(200 + o / SW);
                break;
            end
        end
        for (int k = 0; k < 16; k++) begin
            xs.push_back($urandom_range(98, 117)); ys.push_back($urandom_range(198, 225));
        end
        n = xs.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                e = expq.pop_front();
                checks++;
                if (obs_pix !== e) begin
                    errors++; $display("FAIL window_pix%0d (%0d,%0d): got %h want %h", i - 3, xs[i-3], ys[i-3], obs_pix, e);
                end
            end
            if (i < n) begin
                DrawX = 10'(xs[i]); DrawY = 10'(ys[i]);
                expq.push_back(exp_pixel(xs[i], ys[i]));
            end
            @(posedge Clk); #1;
        end
        $display("test_window done");
    endtask

    task automatic test_right_edge();
        logic [24:0] expq[$];
        logic [24:0] e;
        int xs[$];
        do_tick(1'b1, 2, 630, 10);
        for (int x = 630; x <= 639; x++) xs.push_back(x);
        for (int x = 0; x <= 5; x++) xs.push_back(x);
        for (int i = 0; i < xs.size() + 3; i++) begin
            if (i >= 3) begin
                e = expq.pop_front();
                checks++;
                if (obs_pix !== e) begin
                    errors++; $display("FAIL edge_pix x=%0d: got %h want %h", xs[i-3], obs_pix, e);
                end
            end
            if (i < xs.size()) begin
                DrawX = 10'(xs[i]); DrawY = 10'd13;
                expq.push_back(exp_pixel(xs[i], 13));
            end
            @(posedge Clk); #1;
        end
        $display("test_right_edge done");
    endtask

    task automatic test_random_stream();
        logic [24:0] expq[$];
        logic [24:0] e;
        int n, dx, dy, d, sx, sy;
        bit tk, mv;
        n = 1500;
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                e = expq.pop_front();
                checks++;
                if (obs_pix !== e) begin
                    errors++; $display("FAIL random_pix%0d: got %h want %h", i - 3, obs_pix, e);
                end
            end
            tk = 1'b0;
            if (i < n) begin
                if ($urandom_range(0, 3) == 0) begin
                    dx = $urandom_range(0, 1023); dy = $urandom_range(0, 1023);
                end else begin
                    dx = (m_px + 1024 + $urandom_range(0, SW + 5) - 3) % 1024;
                    dy = (m_py + 1024 + $urandom_range(0, SH + 5) - 3) % 1024;
                end
                tk = ($urandom_range(0, 3) == 0);
                mv = ($urandom_range(0, 19) != 0);
                d  = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : m_dir;
                sx = $urandom_range(0, 1023); sy = $urandom_range(0, 1023);
                DrawX = 10'(dx); DrawY = 10'(dy);
                Character_Moving = mv; Direction = 2'(d);
                SpriteX = 10'(sx); SpriteY = 10'(sy);
                expq.push_back(exp_pixel(dx, dy));
                if (tk) model_tick(mv, d, sx, sy);
            end
            frame_tick = tk;
            @(posedge Clk); #1;
        end
        frame_tick = 1'b0;
        $display("test_random_stream done");
    endtask

    task automatic test_reset_mid_anim();
        do_tick(1'b1, 3, 300, 300);
        for (int t = 0; t < 24; t++) do_tick(1'b1, 3, 300, 300);
        checks++;
        if (obs_frame !== 4'd15 || obs_frame !== 4'(m_frame())) begin
            errors++; $display("FAIL mid_pre_state: got frame %0d want 15", obs_frame);
        end
        DrawX = 10'd40; DrawY = 10'd5;
        repeat (3) @(posedge Clk); #1;
        checks++;
        if (obs_pix !== exp_pixel(40, 5)) begin
            errors++; $display("FAIL mid_pre_pix: got %h want %h", obs_pix, exp_pixel(40, 5));
        end
        @(negedge Clk); #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (obs_pix !== 25'h0) begin
            errors++; $display("FAIL mid_async_pix: got %h want %h", obs_pix, 25'h0);
        end
        checks++;
        if (obs_frame !== 4'd8 || obs_cnt !== 4'd0 || obs_px !== 10'd0 || obs_py !== 10'd0) begin
            errors++; $display("FAIL mid_async_state: got frame %0d cnt %0d pos %0d,%0d want 8 0 0,0",
                               obs_frame, obs_cnt, obs_px, obs_py);
        end
        frame_tick = 1'b1; Character_Moving = 1'b1; Direction = 2'd1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        checks++;
        if (obs_frame !== 4'd8 || obs_px !== 10'd0) begin
            errors++; $display("FAIL mid_tick_in_reset: got frame %0d posX %0d want 8 0", obs_frame, obs_px);
        end
        Reset = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk); #1;
        checks++;
        if (obs_pix !== exp_pixel(40, 5)) begin
            errors++; $display("FAIL mid_refill: got %h want %h", obs_pix, exp_pixel(40, 5));
        end
        $display("test_reset_mid_anim done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_walk();
        test_turn_stop();
        test_window();
        test_right_edge();
        test_random_stream();
        test_reset_mid_anim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
